// File: rtl/rs232_avalon_slave.sv
// Avalon-MM UART endpoint: RX FIFO at offset 0, TX holding register at offset 4, status at offset 8.
// Every bus access takes two cycles: the request is captured in IDLE and acknowledged in ACK.
module rs232_avalon_slave #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic [4:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        avs_waitrequest,
  input  logic        uart_rxd,
  output logic        uart_txd
);
  // Bus handshake: the master holds address/read/write while avs_waitrequest=1.
  // The access completes in the single cycle where avs_waitrequest=0, and
  // avs_readdata is valid in that same cycle.

  localparam int TW    = $clog2(CLKS_PER_BIT) + 1;
  localparam int PTR_W = $clog2(RX_FIFO_DEPTH);
  localparam logic [TW-1:0]  BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]  HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W + 1)'(RX_FIFO_DEPTH);

  typedef enum logic       {B_IDLE, B_ACK} bus_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  bus_state_t bus_state, bus_next;
  rx_state_t  rx_state, rx_next;
  tx_state_t  tx_state, tx_next;

  // ---------------- bus side ----------------
  logic        pop_q, load_q, clr_fe_q, clr_ov_q;
  logic [7:0]  wdata_q;
  logic [31:0] rdata_q;
  logic        req, is_rd, is_wr, ack;
  logic        rx_ok, tx_ok, frame_err, rx_overrun;
  logic [7:0]  status_byte, head;
  logic [31:0] rd_value;
  logic        rx_pop, tx_load;
  logic        unused_wdata;

  assign unused_wdata = ^avs_writedata[31:8];

  assign req   = avs_read | avs_write;
  assign is_rd = avs_read;
  assign is_wr = avs_write & ~avs_read;
  assign ack   = (bus_state == B_ACK);

  assign status_byte = {rx_ok, tx_ok, 3'b000, frame_err, 1'b0, rx_overrun};

  always_comb begin
    rd_value = 32'd0;
    if (is_rd) begin
      case (avs_address)
        5'd0:    rd_value = rx_ok ? {24'd0, head} : 32'd0;
        5'd8:    rd_value = {24'd0, status_byte};
        default: rd_value = 32'd0;
      endcase
    end
  end

  always_comb begin
    bus_next = bus_state;
    case (bus_state)
      B_IDLE:  if (req) bus_next = B_ACK;
      B_ACK:   bus_next = B_IDLE;
      default: bus_next = B_IDLE;
    endcase
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      bus_state <= B_IDLE;
      rdata_q   <= 32'd0;
      pop_q     <= 1'b0;
      load_q    <= 1'b0;
      clr_fe_q  <= 1'b0;
      clr_ov_q  <= 1'b0;
      wdata_q   <= 8'd0;
    end else begin
      bus_state <= bus_next;
      if (bus_state == B_IDLE && req) begin
        rdata_q  <= rd_value;
        wdata_q  <= avs_writedata[7:0];
        pop_q    <= is_rd && (avs_address == 5'd0) && rx_ok;
        load_q   <= is_wr && (avs_address == 5'd4) && tx_ok;
        clr_fe_q <= is_rd && (avs_address == 5'd8) && frame_err;
        clr_ov_q <= is_rd && (avs_address == 5'd8) && rx_overrun;
      end
    end
  end

  assign avs_waitrequest = ~ack;
  assign avs_readdata    = rdata_q;
  assign rx_pop          = ack & pop_q;
  assign tx_load         = ack & load_q;

  // ---------------- RX path ----------------
  logic          rx_s1, rx_s2;
  logic [TW-1:0] rx_timer;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_tick, rx_push, rx_ferr;

  assign rx_tick = (rx_timer == '0);

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:  if (!rx_s2) rx_next = R_START;
      R_START: if (rx_tick) rx_next = rx_s2 ? R_IDLE : R_DATA;
      R_DATA:  if (rx_tick && rx_idx == 3'd7) rx_next = R_STOP;
      R_STOP:  if (rx_tick) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  assign rx_push = (rx_state == R_STOP) && rx_tick && rx_s2;
  assign rx_ferr = (rx_state == R_STOP) && rx_tick && !rx_s2;

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= R_IDLE;
      rx_timer <= '0;
      rx_idx   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      rx_s1    <= uart_rxd;
      rx_s2    <= rx_s1;
      rx_state <= rx_next;
      case (rx_state)
        R_IDLE: rx_timer <= HALF_LAST;
        R_START: begin
          if (rx_tick) begin
            rx_timer <= BIT_LAST;
            rx_idx   <= 3'd0;
          end else rx_timer <= rx_timer - 1'b1;
        end
        R_DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_idx   <= rx_idx + 1'b1;
            rx_timer <= BIT_LAST;
          end else rx_timer <= rx_timer - 1'b1;
        end
        R_STOP: if (!rx_tick) rx_timer <= rx_timer - 1'b1;
        default: rx_timer <= '0;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]       mem [RX_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, push_ok;

  assign full    = (count == FULL_CNT);
  assign rx_ok   = (count != '0);
  assign head    = mem[rd_ptr];
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = rx_push && (!full || rx_pop);

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      frame_err  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= rx_shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rx_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, rx_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      frame_err  <= (frame_err & ~(ack & clr_fe_q)) | rx_ferr;
      rx_overrun <= (rx_overrun & ~(ack & clr_ov_q)) | (rx_push & ~push_ok);
    end
  end

  // ---------------- TX path ----------------
  logic [TW-1:0] tx_timer;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic          tx_tick;

  assign tx_tick = (tx_timer == '0);
  assign tx_ok   = (tx_state == T_IDLE);

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      T_IDLE:  if (tx_load) tx_next = T_START;
      T_START: if (tx_tick) tx_next = T_DATA;
      T_DATA:  if (tx_tick && tx_idx == 3'd7) tx_next = T_STOP;
      T_STOP:  if (tx_tick) tx_next = T_IDLE;
      default: tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      tx_state <= T_IDLE;
      tx_timer <= '0;
      tx_idx   <= 3'd0;
      tx_shift <= 8'd0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_next;
      case (tx_state)
        T_IDLE: begin
          if (tx_load) begin
            tx_shift <= wdata_q;
            tx_timer <= BIT_LAST;
            uart_txd <= 1'b0;
          end
        end
        T_START: begin
          if (tx_tick) begin
            uart_txd <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_idx   <= 3'd0;
            tx_timer <= BIT_LAST;
          end else tx_timer <= tx_timer - 1'b1;
        end
        T_DATA: begin
          if (tx_tick) begin
            if (tx_idx == 3'd7) uart_txd <= 1'b1;
            else begin
              uart_txd <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
            tx_idx   <= tx_idx + 1'b1;
            tx_timer <= BIT_LAST;
          end else tx_timer <= tx_timer - 1'b1;
        end
        T_STOP: if (!tx_tick) tx_timer <= tx_timer - 1'b1;
        default: uart_txd <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_avalon_slave.sv
// Testbench for rs232_avalon_slave with CLKS_PER_BIT=4 and a 4-entry RX FIFO.
// Expected RX bytes and TX line levels are queued when stimulus is driven and popped on DUT output.
module tb_rs232_avalon_slave;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  address;
  logic        read, write;
  logic [31:0] writedata, readdata;
  logic        waitrequest;
  logic        rxd, txd;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rx_exp_q[$];
  logic [31:0] tx_exp_q[$];

  rs232_avalon_slave #(.CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(DEPTH)) dut (
    .avm_clk(clk),
    .avm_rst(rst),
    .avs_address(address),
    .avs_read(read),
    .avs_readdata(readdata),
    .avs_write(write),
    .avs_writedata(writedata),
    .avs_waitrequest(waitrequest),
    .uart_rxd(rxd),
    .uart_txd(txd)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_access(input logic [4:0] addr, input logic rd, input logic wr,
                            input logic [31:0] wdata, output logic [31:0] rdata);
    int waits;
    @(posedge clk); #1;
    address = addr; read = rd; write = wr; writedata = wdata;
    waits = 0;
    @(negedge clk);
    while (waitrequest && waits < 8) begin
      waits++;
      @(negedge clk);
    end
    rdata = readdata;
    check("wait_cycles", 32'(waits), 32'd1);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_access(addr, 1'b1, 1'b0, 32'd0, d);
    check(tag, d, exp);
  endtask

  task automatic rd_rx(input string tag);
    logic [31:0] exp;
    exp = (rx_exp_q.size() != 0) ? rx_exp_q.pop_front() : 32'd0;
    rd_check(tag, 5'd0, exp);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    logic [31:0] d;
    bus_access(addr, 1'b0, 1'b1, data, d);
  endtask

  // Drives one frame on rxd; a good frame joins the expected FIFO if there is room.
  task automatic send_byte(input logic [7:0] data, input logic stop_bit, input bit accepted);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    if (accepted) rx_exp_q.push_back({24'd0, data});
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
  endtask

  task automatic queue_tx_frame(input logic [7:0] data);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < CPB; j++) tx_exp_q.push_back({31'd0, frame[i]});
  endtask

  task automatic watch_tx();
    int i;
    i = 0;
    while (tx_exp_q.size() != 0) begin
      @(negedge clk);
      check($sformatf("txd[%0d]", i), {31'd0, txd}, tx_exp_q.pop_front());
      i++;
    end
  endtask

  initial begin
    rst = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0; rxd = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_waitrequest", {31'd0, waitrequest}, 32'd1);
    check("rst_readdata", readdata, 32'd0);
    check("rst_txd", {31'd0, txd}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: idle status
    rd_check("status_idle", 5'd8, 32'h40);
    check("txd_idle", {31'd0, txd}, 32'd1);
    rd_check("read_tx_reg", 5'd4, 32'd0);
    rd_check("read_other", 5'd12, 32'd0);
    rd_rx("rx_empty_read");

    // 2: single received byte
    send_byte(8'hA5, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    rd_check("status_rx", 5'd8, 32'hC0);
    rd_rx("rx_a5");
    rd_check("status_after_pop", 5'd8, 32'h40);

    // 3 + 6a: transmit 0x3C; a second write mid-frame must be dropped
    wr(5'd4, 32'hFFFF_FF3C);
    queue_tx_frame(8'h3C);
    fork
      watch_tx();
      begin
        rd_check("status_tx_busy", 5'd8, 32'h00);
        wr(5'd4, 32'h0000_00FF);
      end
    join
    rd_check("status_tx_done", 5'd8, 32'h40);
    check("txd_after_frame", {31'd0, txd}, 32'd1);

    // writes to RX/status offsets are ignored
    wr(5'd0, 32'h55);
    wr(5'd8, 32'hFF);
    rd_check("status_after_ign_wr", 5'd8, 32'h40);

    // 4: overrun with a full FIFO
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, i <= DEPTH);
    repeat (4) @(posedge clk);
    rd_check("status_overrun", 5'd8, 32'hC1);
    for (int i = 0; i < DEPTH; i++) rd_rx($sformatf("rx_fifo[%0d]", i));
    rd_check("status_drained", 5'd8, 32'h40);

    // 5: framing error, then a start-bit glitch
    send_byte(8'h5A, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    rd_check("status_frame_err", 5'd8, 32'h44);
    rd_check("status_fe_cleared", 5'd8, 32'h40);
    @(posedge clk); #1; rxd = 1'b0;
    @(posedge clk); #1; rxd = 1'b1;
    repeat (20) @(posedge clk);
    rd_check("status_glitch", 5'd8, 32'h40);
    rd_rx("rx_glitch_empty");

    // 6b: reset in the middle of a transmit frame
    wr(5'd4, 32'h00);
    repeat (10) @(negedge clk);
    check("txd_mid_frame", {31'd0, txd}, 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("txd_after_reset", {31'd0, txd}, 32'd1);
    check("wait_after_reset", {31'd0, waitrequest}, 32'd1);
    rd_check("status_after_reset", 5'd8, 32'h40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
